// File: rtl/phase_acc.sv
// Numerically controlled phase accumulator feeding the Q1.15 phase input of the cosine stage.
// Optional linear frequency sweep is compiled in when PHASE_ACC_SWEEP_EN is defined.
module phase_acc #(
  parameter int ACC_W          = 32,
  parameter int UPDATE_ON_WRAP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             phase_clr,
  input  logic [ACC_W-1:0] freq,
  input  logic             freq_valid,
  output logic             freq_ready,
  input  logic [15:0]      offset,
  input  logic             offset_load,
`ifdef PHASE_ACC_SWEEP_EN
  input  logic [ACC_W-1:0] sweep_step,
`endif
  output logic [15:0]      source,
  output logic             wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ARMED = 2'd2
  } state_t;

  state_t           state_r;
  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] freq_r;
  logic [ACC_W-1:0] freq_pend_r;
  logic [15:0]      offset_r;

  logic [ACC_W:0]   sum_s;
  logic [ACC_W-1:0] acc_next_s;
  logic             wrap_s;
  logic             step_s;
  logic             accept_s;

`ifdef PHASE_ACC_SWEEP_EN
  // Signed add that clamps to the representable range instead of wrapping.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1]) begin
      sat_add = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      sat_add = s[ACC_W-1:0];
    end
  endfunction
`endif

  // Next accumulator value and crossing detection; a negative word wraps on borrow (no carry).
  always_comb begin
    sum_s      = {1'b0, acc_r} + {1'b0, freq_r};
    acc_next_s = sum_s[ACC_W-1:0];
    if (freq_r[ACC_W-1]) begin
      wrap_s = ~sum_s[ACC_W];
    end else begin
      wrap_s = sum_s[ACC_W];
    end
    step_s   = (state_r != IDLE) && enable && !phase_clr;
    accept_s = freq_valid && freq_ready;
  end

  // Accumulator, outputs, frequency handshake and mode state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      acc_r       <= '0;
      freq_r      <= '0;
      freq_pend_r <= '0;
      offset_r    <= 16'h0000;
      source      <= 16'h0000;
      wrap        <= 1'b0;
      freq_ready  <= 1'b1;
    end else begin
      if (offset_load) begin
        offset_r <= offset;
      end

      wrap <= 1'b0;
      if (phase_clr) begin
        acc_r  <= '0;
        source <= offset_r;
      end else if (step_s) begin
        acc_r  <= acc_next_s;
        source <= acc_next_s[ACC_W-1 -: 16] + offset_r;
        wrap   <= wrap_s;
      end

      case (state_r)
        IDLE: begin
          if (accept_s) begin
            freq_r <= freq;
          end
          if (enable) begin
            state_r <= RUN;
          end
        end
        RUN: begin
`ifdef PHASE_ACC_SWEEP_EN
          if (enable) begin
            freq_r <= sat_add(freq_r, sweep_step);
          end
`endif
          if (!enable) begin
            state_r <= IDLE;
            if (accept_s) begin
              freq_r <= freq;
            end
          end else if (accept_s) begin
            if (UPDATE_ON_WRAP != 0) begin
              // Hold the new word until the next crossing so the phase stays continuous.
              freq_pend_r <= freq;
              freq_ready  <= 1'b0;
              state_r     <= ARMED;
            end else begin
              freq_r <= freq;
            end
          end
        end
        ARMED: begin
          if (!enable) begin
            freq_r     <= freq_pend_r;
            freq_ready <= 1'b1;
            state_r    <= IDLE;
          end else if (step_s && wrap_s) begin
            freq_r     <= freq_pend_r;
            freq_ready <= 1'b1;
            state_r    <= RUN;
          end
        end
        default: begin
          state_r    <= IDLE;
          freq_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_acc.sv
// Self-checking bench for phase_acc (ACC_W=32, UPDATE_ON_WRAP=1) against a turn-counting reference model.
// Sweep checks are compiled in when PHASE_ACC_SWEEP_EN is defined.
module tb_phase_acc;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        phase_clr;
  logic [31:0] freq;
  logic        freq_valid;
  logic        freq_ready;
  logic [15:0] offset;
  logic        offset_load;
  logic [15:0] source;
  logic        wrap;
`ifdef PHASE_ACC_SWEEP_EN
  logic [31:0] sweep_step;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase as an integer in [0, 2^32), frequency as a signed integer.
  localparam longint TWO32 = 64'sd4294967296;
  longint      m_acc;
  longint      m_freq;
  longint      m_pend[$];
  logic [15:0] m_off;
  logic [15:0] m_src;
  logic        m_wrap;
  logic        m_ready;
  bit          m_active;

  phase_acc #(.ACC_W(32), .UPDATE_ON_WRAP(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .phase_clr   (phase_clr),
    .freq        (freq),
    .freq_valid  (freq_valid),
    .freq_ready  (freq_ready),
    .offset      (offset),
    .offset_load (offset_load),
`ifdef PHASE_ACC_SWEEP_EN
    .sweep_step  (sweep_step),
`endif
    .source      (source),
    .wrap        (wrap)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    longint t;
    bit     accept;
    bit     crossed;
    accept  = freq_valid && m_ready;
    crossed = 1'b0;
    if (reset) begin
      m_acc = 0; m_freq = 0; m_pend.delete(); m_off = 16'h0000;
      m_src = 16'h0000; m_wrap = 1'b0; m_ready = 1'b1; m_active = 1'b0;
      return;
    end
    if (phase_clr) begin
      m_acc = 0;
      m_src = m_off;
    end else if (m_active && enable) begin
      t = m_acc + m_freq;
      if (t >= TWO32) begin t = t - TWO32; crossed = 1'b1; end
      if (t < 0)      begin t = t + TWO32; crossed = 1'b1; end
      m_acc = t;
      m_src = 16'((m_acc >> 16) + longint'(m_off));
    end
    m_wrap = crossed;
    if (!m_active) begin
      if (accept) m_freq = longint'($signed(freq));
      m_active = enable;
    end else if (!enable) begin
      if (m_pend.size() != 0) m_freq = m_pend.pop_front();
      else if (accept) m_freq = longint'($signed(freq));
      m_active = 1'b0;
    end else if (m_pend.size() != 0) begin
      if (crossed) m_freq = m_pend.pop_front();
    end else begin
`ifdef PHASE_ACC_SWEEP_EN
      m_freq = m_freq + longint'($signed(sweep_step));
      if (m_freq > 64'sd2147483647)  m_freq = 64'sd2147483647;
      if (m_freq < -64'sd2147483648) m_freq = -64'sd2147483648;
`endif
      if (accept) m_pend.push_back(longint'($signed(freq)));
    end
    m_ready = (m_pend.size() == 0);
    if (offset_load) m_off = offset;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enable = 1'b0; phase_clr = 1'b0; freq = 32'h0; freq_valid = 1'b0;
    offset = 16'h0; offset_load = 1'b0;
`ifdef PHASE_ACC_SWEEP_EN
    sweep_step = 32'h0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic load_and_start(input logic [31:0] f);
    freq = f; freq_valid = 1'b1;
    tick();
    freq_valid = 1'b0; enable = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({source, wrap, freq_ready} !== {16'h0000, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: got src=%h wrap=%b rdy=%b, want src=0000 wrap=0 rdy=1", source, wrap, freq_ready);
    end
  endtask

  task automatic test_positive_ramp();
    int wraps = 0;
    do_reset();
    load_and_start(32'h0100_0000);
    tick();
    n_checks++;
    if ({source, wrap} !== {16'h0100, 1'b0}) begin
      n_fail++;
      $display("FAIL pos_first_step: got src=%h wrap=%b, want src=0100 wrap=0", source, wrap);
    end
    for (int i = 0; i < 260; i++) begin
      tick();
      if (wrap) begin
        wraps++;
        n_checks++;
        if (source !== 16'h0000) begin
          n_fail++;
          $display("FAIL pos_wrap_at_zero: got src=%h, want 0000", source);
        end
      end
      n_checks++;
      if ({source, wrap, freq_ready} !== {m_src, m_wrap, m_ready}) begin
        n_fail++;
        $display("FAIL pos_ramp cyc %0d: got %h/%b/%b, want %h/%b/%b", i, source, wrap, freq_ready, m_src, m_wrap, m_ready);
      end
    end
    n_checks++;
    if (wraps !== 1) begin
      n_fail++;
      $display("FAIL pos_wrap_count: got %0d, want 1", wraps);
    end
  endtask

  task automatic test_negative_ramp();
    do_reset();
    load_and_start(32'hFF00_0000);
    tick();
    n_checks++;
    if ({source, wrap} !== {16'hFF00, 1'b1}) begin
      n_fail++;
      $display("FAIL neg_first_step: got src=%h wrap=%b, want src=FF00 wrap=1", source, wrap);
    end
    for (int i = 0; i < 300; i++) begin
      tick();
      n_checks++;
      if ({source, wrap, freq_ready} !== {m_src, m_wrap, m_ready}) begin
        n_fail++;
        $display("FAIL neg_ramp cyc %0d: got %h/%b/%b, want %h/%b/%b", i, source, wrap, freq_ready, m_src, m_wrap, m_ready);
      end
    end
  endtask

  task automatic test_deferred_update();
    logic [15:0] prev;
    bit          seen = 1'b0;
    do_reset();
    load_and_start(32'h0100_0000);
    repeat (50) tick();
    freq = 32'h0200_0000; freq_valid = 1'b1;
    tick();
    freq_valid = 1'b0;
    n_checks++;
    if (freq_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL defer_ready_low: got %b, want 0", freq_ready);
    end
    for (int i = 0; i < 300 && !seen; i++) begin
      prev = source;
      tick();
      seen = wrap;
      n_checks++;
      if ((16'(source - prev) !== 16'h0100) || ({source, wrap, freq_ready} !== {m_src, m_wrap, m_ready})) begin
        n_fail++;
        $display("FAIL defer_old_step cyc %0d: got %h->%h, want step 0100 (model %h)", i, prev, source, m_src);
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL defer_wrap_timeout: got no wrap, want wrap within 300 cycles");
    end
    prev = source;
    tick();
    n_checks++;
    if ({16'(source - prev), freq_ready} !== {16'h0200, 1'b1}) begin
      n_fail++;
      $display("FAIL defer_new_step: got step=%h rdy=%b, want step=0200 rdy=1", 16'(source - prev), freq_ready);
    end
  endtask

  task automatic test_offset_clr();
    logic [15:0] prev;
    do_reset();
    load_and_start(32'h0100_0000);
    repeat (10) tick();
    offset = 16'h4000; offset_load = 1'b1;
    prev = source;
    tick();
    offset_load = 1'b0;
    n_checks++;
    if (16'(source - prev) !== 16'h0100) begin
      n_fail++;
      $display("FAIL offset_not_yet: got step=%h, want 0100", 16'(source - prev));
    end
    prev = source;
    tick();
    n_checks++;
    if (16'(source - prev) !== 16'h4100) begin
      n_fail++;
      $display("FAIL offset_jump: got step=%h, want 4100", 16'(source - prev));
    end
    phase_clr = 1'b1;
    tick();
    phase_clr = 1'b0;
    n_checks++;
    if ({source, wrap} !== {16'h4000, 1'b0}) begin
      n_fail++;
      $display("FAIL clr_value: got src=%h wrap=%b, want src=4000 wrap=0", source, wrap);
    end
    tick();
    n_checks++;
    if ({source, wrap} !== {16'h4100, 1'b0}) begin
      n_fail++;
      $display("FAIL clr_resume: got src=%h wrap=%b, want src=4100 wrap=0", source, wrap);
    end
  endtask

  task automatic test_reset_armed();
    do_reset();
    load_and_start(32'h0100_0000);
    repeat (10) tick();
    freq = 32'h0200_0000; freq_valid = 1'b1;
    tick();
    freq_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({source, wrap, freq_ready} !== {16'h0000, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL armed_reset: got src=%h wrap=%b rdy=%b, want 0000/0/1", source, wrap, freq_ready);
    end
    repeat (6) tick();
    n_checks++;
    if ({source, wrap} !== {16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL armed_reset_discard: got src=%h wrap=%b, want 0000/0", source, wrap);
    end
  endtask

  task automatic test_half_turn();
    do_reset();
    load_and_start(32'h8000_0000);
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if ({source, wrap} !== {((i % 2) == 0) ? 16'h8000 : 16'h0000, ((i % 2) == 0)}) begin
        n_fail++;
        $display("FAIL half_turn cyc %0d: got src=%h wrap=%b", i, source, wrap);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 299) == 0);
      enable      = ($urandom_range(0, 9) != 0);
      phase_clr   = ($urandom_range(0, 59) == 0);
      freq_valid  = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0:       freq = 32'h8000_0000;
        1:       freq = 32'h0000_0000;
        2:       freq = $urandom() >> 4;
        3:       freq = -($urandom() >> 4);
        default: freq = $urandom();
      endcase
      offset_load = ($urandom_range(0, 19) == 0);
      offset      = 16'($urandom());
      tick();
      n_checks++;
      if ({source, wrap, freq_ready} !== {m_src, m_wrap, m_ready}) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h/%b/%b, want %h/%b/%b", i, source, wrap, freq_ready, m_src, m_wrap, m_ready);
      end
    end
    idle_inputs();
  endtask

`ifdef PHASE_ACC_SWEEP_EN
  task automatic test_sweep();
    do_reset();
    sweep_step = 32'h0000_0100;
    load_and_start(32'h7FFF_FF00);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ((dut.freq_r !== 32'h7FFF_FFFF) || ({source, wrap} !== {m_src, m_wrap})) begin
        n_fail++;
        $display("FAIL sweep_sat cyc %0d: got freq_r=%h src=%h, want 7FFFFFFF src=%h", i, dut.freq_r, source, m_src);
      end
    end
    sweep_step = 32'h0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    idle_inputs();
    m_pend.delete();
    test_reset();
    test_positive_ramp();
    test_negative_ramp();
    test_deferred_update();
    test_offset_clr();
    test_reset_armed();
    test_half_turn();
    test_random();
`ifdef PHASE_ACC_SWEEP_EN
    test_sweep();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
